// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: counters, active-area coordinates and strobes,
// plus sync/enable outputs delayed LEAD cycles behind the coordinates.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter bit H_POL    = 1'b0,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit V_POL    = 1'b0,
    parameter int CW       = 10,
    parameter int LEAD     = 2,
    parameter int FRAME_W  = 8
) (
    input  logic               vga_clock,
    input  logic               rst,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               dsp_en,
    output logic [CW-1:0]      vga_x,
    output logic [CW-1:0]      vga_y,
    output logic               line_start,
    output logic               frame_start,
    output logic               end_of_frame,
    output logic               vblank,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
        $error("vga_timing_gen: active/porch/sync parameters must all be >= 1");
    end
    if (LEAD < 0 || LEAD > 15) begin : g_bad_lead
        $error("vga_timing_gen: LEAD must be in 0..15");
    end
    if (CW < 1 || CW > 30 || H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_cw
        $error("vga_timing_gen: CW too narrow for H_TOTAL-1 / V_TOTAL-1");
    end
    if (FRAME_W < 1) begin : g_bad_fw
        $error("vga_timing_gen: FRAME_W must be >= 1");
    end

    localparam logic [CW-1:0] H_END    = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_END    = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_LAST   = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
    // Delay-line word layout: {de, hs, vs}, with hs/vs already at output polarity.
    localparam logic [2:0]    SYNC_IDLE = {1'b0, ~H_POL, ~V_POL};

    logic [CW-1:0]      h_cnt_q, h_cnt_d;
    logic [CW-1:0]      v_cnt_q, v_cnt_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CW-1:0]      x_q, y_q;
    logic               line_start_q, frame_start_q, eof_q, vblank_q;
    logic [2:0]         sync_q [0:LEAD];

    logic       h_wrap, v_wrap, h_act, v_act;
    logic       hs_win, vs_win;
    logic [2:0] sync_d;

    always_comb begin
        h_wrap      = (h_cnt_q == H_END);
        v_wrap      = (v_cnt_q == V_END);
        h_act       = (h_cnt_q < H_ACT);
        v_act       = (v_cnt_q < V_ACT);
        hs_win      = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
        vs_win      = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
        h_cnt_d     = h_wrap ? '0 : h_cnt_q + 1'b1;
        v_cnt_d     = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
        end
        frame_cnt_d = (h_wrap && v_wrap) ? frame_cnt_q + 1'b1 : frame_cnt_q;
        sync_d      = {h_act && v_act,
                       hs_win ? H_POL : ~H_POL,
                       vs_win ? V_POL : ~V_POL};
    end

    always_ff @(posedge vga_clock) begin
        if (rst) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            frame_cnt_q   <= '0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            eof_q         <= 1'b0;
            vblank_q      <= 1'b0;
            for (int i = 0; i <= LEAD; i++) begin
                sync_q[i] <= SYNC_IDLE;
            end
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            x_q           <= (h_act && v_act) ? h_cnt_q : '0;
            y_q           <= (h_act && v_act) ? v_cnt_q : '0;
            line_start_q  <= (h_cnt_q == '0) && v_act;
            frame_start_q <= (h_cnt_q == '0) && (v_cnt_q == '0);
            eof_q         <= (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
            vblank_q      <= !v_act;
            sync_q[0]     <= sync_d;
            for (int i = 1; i <= LEAD; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign vga_x        = x_q;
    assign vga_y        = y_q;
    assign line_start   = line_start_q;
    assign frame_start  = frame_start_q;
    assign end_of_frame = eof_q;
    assign vblank       = vblank_q;
    assign frame_cnt    = frame_cnt_q;
    assign dsp_en       = sync_q[LEAD][2];
    assign vga_hs       = sync_q[LEAD][1];
    assign vga_vs       = sync_q[LEAD][0];

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Fully parametrised VGA/raster timing generator. It replaces the fixed 640x480 generator and its internal power-on reset timer.
- Produces H/V sync, display enable, active-area pixel coordinates, line/frame strobes and a frame counter.
- Has a programmable LEAD: coordinates run LEAD cycles ahead of sync/enable, so downstream pixel pipelines (sprite/ball/paddle renderers, RAM lookups) can be latency-matched.
- Sits between the pixel-clock PLL and the game renderer/colour mux.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (cycles)
H_SYNC, 96, hsync width (cycles)
H_BP, 48, horizontal back porch (cycles)
H_POL, 0, hsync active level (0 = active-low)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
V_POL, 0, vsync active level
CW, 10, width of coordinate and counter buses; must hold H_TOTAL-1 and V_TOTAL-1
LEAD, 2, extra delay (0..15 cycles) of vga_hs/vga_vs/dsp_en relative to vga_x/vga_y
FRAME_W, 8, frame counter width

Ports:
vga_clock  in  1  pixel clock
rst  in  1  synchronous, active-high reset
vga_hs  out  1  horizontal sync, polarity H_POL
vga_vs  out  1  vertical sync, polarity V_POL
dsp_en  out  1  display enable (active area), LEAD-delayed
vga_x  out  CW  active-area column, 0 outside active area
vga_y  out  CW  active-area row, 0 outside active area
line_start  out  1  1-cycle strobe: first pixel of an active line
frame_start  out  1  1-cycle strobe: pixel (0,0)
end_of_frame  out  1  1-cycle strobe: pixel (H_ACTIVE-1, V_ACTIVE-1)
vblank  out  1  high while line index >= V_ACTIVE, aligned with vga_x/vga_y
frame_cnt  out  FRAME_W  completed-frame count, modulo 2^FRAME_W

Behaviour:
- Reset is synchronous on vga_clock, rst active-high.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Counter layout per line: active, FP, sync, BP. Per frame: same order.
- Counters:
  - h_cnt counts 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments only when h_cnt wraps; it counts 0..V_TOTAL-1 and wraps to 0.
- Reset while rst=1:
  - h_cnt=v_cnt=0, frame_cnt=0.
  - vga_x=vga_y=0; all strobes 0; vblank=0; dsp_en=0.
  - vga_hs=~H_POL, vga_vs=~V_POL.
  - All LEAD delay-line stages are loaded with these inactive values.
  - Reset asserted mid-frame takes effect at the next edge, with no partial line.
- Stage 1 (registered from counters, 1-cycle latency):
  - vga_x=h_cnt if h_cnt<H_ACTIVE and v_cnt<V_ACTIVE, else 0; vga_y likewise with v_cnt.
  - line_start=(h_cnt==0 && v_cnt<V_ACTIVE).
  - frame_start=(h_cnt==0 && v_cnt==0).
  - end_of_frame=(h_cnt==H_ACTIVE-1 && v_cnt==V_ACTIVE-1).
  - vblank=(v_cnt>=V_ACTIVE).
- Sync/enable generation (stage 1 value, then delayed by LEAD registers):
  - de_raw=(h_cnt<H_ACTIVE && v_cnt<V_ACTIVE).
  - hs_raw active iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vs_raw active iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC. vs_raw therefore changes only at h_cnt==0.
  - LEAD=0: vga_hs/vga_vs/dsp_en are cycle-aligned with vga_x/vga_y.
- Timing from reset release (edge 0 = first edge with rst=0):
  - After edge 0: vga_x=0, vga_y=0, frame_start=1, line_start=1.
  - After edge LEAD: dsp_en=1.
- frame_cnt:
  - Increments on the edge where the counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0).
  - Wraps from 2^FRAME_W-1 to 0.
  - The first frame after reset reads 0.
- Exact periods:
  - hsync: H_TOTAL cycles; sync width exactly H_SYNC cycles.
  - vsync: H_TOTAL*V_TOTAL cycles; sync width exactly V_SYNC*H_TOTAL cycles.
- Strobe counts per frame: each strobe is exactly one cycle wide. frame_start and end_of_frame fire exactly once per frame; line_start fires V_ACTIVE times.
- Elaboration error if any porch/sync/active parameter < 1, LEAD > 15, or CW is too narrow.

Test Plan:
- Small config (H 8/2/3/3 = 16, V 4/1/2/1 = 8, LEAD=2, pol 0), rst released at edge 0:
  - after edge 0: frame_start=1, vga_x=0, vga_y=0;
  - after edge 2: dsp_en=1;
  - vga_x sequence 0..7, then 0 for 8 cycles;
  - vga_hs low for exactly 3 cycles, starting 10+2 cycles after line start.
- Small config, frame boundaries:
  - end_of_frame high exactly once per 128 cycles, when vga_x=7, vga_y=3;
  - vga_vs low for 32 cycles, 5 lines into the frame (plus LEAD);
  - vblank high for lines 4..7;
  - frame_cnt increments 0 -> 1 after 128 cycles.
- Polarity/LEAD=0 config (H_POL=1, V_POL=1): syncs idle low and pulse high; dsp_en edges coincide with the vga_x 0/7 transitions.
- Default 640x480: hs period 800 and low width 96; vs period 420000 and low width 1600; dsp_en high count 307200 per frame; frame_cnt wraps 255 -> 0 after 256 frames.
- Reset mid-line (rst at h_cnt=5, v_cnt=2 for 3 cycles): during rst all outputs show their reset values; after release the frame restarts at (0,0) with frame_start and frame_cnt=0.
